// File: rtl/sfp_ring_node.sv
// SFP ring node: master arbitrates Zynq/DSP frames onto the ring and tracks slave status; slave delivers, forwards, reports.
// RX pulses 1 cycle after i_rx_valid; o_tx_start 2 cycles after selection; requests hold until ack, 1-deep forward buffer drops when full.
module sfp_ring_node #(
    parameter int          N_SLAVE       = 3,
    parameter int          ID_W          = 16,
    parameter int          FRAME_W       = 128,
    parameter logic [15:0] STAT_CMD      = 16'h1111,
    parameter int          STAT_PERIOD   = 200,
    parameter int          TX_TIMEOUT    = 20,
    parameter int          ALIVE_TIMEOUT = 10000
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        i_rst,
    input  logic [ID_W-1:0]             i_node_id,
    input  logic                        i_zynq_req,
    input  logic [FRAME_W-1:0]          i_zynq_frame,
    output logic                        o_zynq_ack,
    input  logic                        i_dsp_req,
    input  logic [FRAME_W-1:0]          i_dsp_frame,
    output logic                        o_dsp_ack,
    input  logic [FRAME_W-16-ID_W-1:0]  i_stat_payload,
    output logic                        o_tx_start,
    output logic [FRAME_W-1:0]          o_tx_frame,
    input  logic                        i_tx_done,
    input  logic                        i_rx_valid,
    input  logic [FRAME_W-1:0]          i_rx_frame,
    output logic                        o_cmd_valid,
    output logic [FRAME_W-1:0]          o_cmd_frame,
    output logic                        o_stat_valid,
    output logic [ID_W-1:0]             o_stat_id,
    output logic [FRAME_W-16-ID_W-1:0]  o_stat_payload,
    output logic [N_SLAVE-1:0]          o_slave_alive,
    output logic [15:0]                 o_timeout_cnt,
    output logic [15:0]                 o_drop_cnt
);
    localparam int PAY_W = FRAME_W - 16 - ID_W;
    localparam int ST_W  = $clog2(STAT_PERIOD);
    localparam int TO_W  = $clog2(TX_TIMEOUT + 1);
    localparam int AL_W  = $clog2(ALIVE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_e;

    state_e             state_q;
    logic [ID_W-1:0]    node_q, node_d;
    logic [FRAME_W-1:0] tx_frame_q, fwd_q, cmd_frame_q;
    logic               tx_start_q, zynq_ack_q, dsp_ack_q, cmd_valid_q, stat_valid_q;
    logic               fwd_vld_q, stat_pend_q;
    logic [TO_W-1:0]    wait_cnt_q;
    logic [ST_W-1:0]    stat_tmr_q;
    logic [15:0]        timeout_cnt_q, drop_cnt_q;
    logic [ID_W-1:0]    stat_id_q;
    logic [PAY_W-1:0]   stat_pay_q;
    logic [AL_W-1:0]    alive_tmr_q [N_SLAVE];
    logic [N_SLAVE-1:0] alive_seen_q;

    logic               is_master, stat_hit, local_hit, fwd_hit, stat_wrap;
    logic               take_fwd, take_zynq, take_dsp, take_stat;
    logic [15:0]        rx_cmd;
    logic [ID_W-1:0]    rx_id;

    // Node ID is only re-sampled in IDLE so a role change never disturbs an in-flight transfer.
    always_comb begin
        node_d    = (state_q == IDLE) ? i_node_id : node_q;
        is_master = (node_d == '0);
        rx_cmd    = i_rx_frame[FRAME_W-1 -: 16];
        rx_id     = i_rx_frame[FRAME_W-17 -: ID_W];
        stat_hit  = i_rx_valid && is_master && rx_cmd == STAT_CMD &&
                    rx_id != '0 && rx_id <= ID_W'(N_SLAVE);
        local_hit = i_rx_valid && !is_master && (rx_id == node_d || rx_id == '1);
        fwd_hit   = i_rx_valid && !is_master && rx_id != node_d;
        take_fwd  = state_q == IDLE && !is_master && fwd_vld_q;
        take_zynq = state_q == IDLE && is_master && i_zynq_req;
        take_dsp  = state_q == IDLE && is_master && !i_zynq_req && i_dsp_req;
        take_stat = state_q == IDLE && !is_master && !fwd_vld_q && stat_pend_q;
        stat_wrap = !is_master && stat_tmr_q == ST_W'(STAT_PERIOD - 1);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (i_rst) begin
            state_q       <= IDLE;
            node_q        <= '0;
            tx_frame_q    <= '0;
            tx_start_q    <= 1'b0;
            zynq_ack_q    <= 1'b0;
            dsp_ack_q     <= 1'b0;
            wait_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            drop_cnt_q    <= '0;
            fwd_vld_q     <= 1'b0;
            fwd_q         <= '0;
            stat_pend_q   <= 1'b0;
            stat_tmr_q    <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_frame_q   <= '0;
            stat_valid_q  <= 1'b0;
            stat_id_q     <= '0;
            stat_pay_q    <= '0;
            alive_seen_q  <= '0;
            for (int k = 0; k < N_SLAVE; k++) alive_tmr_q[k] <= AL_W'(ALIVE_TIMEOUT);
        end else begin
            node_q     <= node_d;
            zynq_ack_q <= 1'b0;
            dsp_ack_q  <= 1'b0;
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_fwd) begin
                        tx_frame_q <= fwd_q;
                        state_q    <= LOAD;
                    end else if (take_zynq) begin
                        tx_frame_q <= i_zynq_frame;
                        zynq_ack_q <= 1'b1;
                        state_q    <= LOAD;
                    end else if (take_dsp) begin
                        tx_frame_q <= i_dsp_frame;
                        dsp_ack_q  <= 1'b1;
                        state_q    <= LOAD;
                    end else if (take_stat) begin
                        tx_frame_q <= {STAT_CMD, node_d, i_stat_payload};
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    tx_start_q <= 1'b1;
                    state_q    <= START;
                end
                START: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT;
                end
                default: begin
                    if (i_tx_done) begin
                        state_q <= IDLE;
                    end else if (wait_cnt_q == TO_W'(TX_TIMEOUT - 1)) begin
                        state_q <= IDLE;
                        if (timeout_cnt_q != 16'hFFFF) timeout_cnt_q <= timeout_cnt_q + 16'd1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TO_W'(1);
                    end
                end
            endcase

            stat_valid_q <= stat_hit;
            if (stat_hit) begin
                stat_id_q  <= rx_id;
                stat_pay_q <= i_rx_frame[PAY_W-1:0];
            end
            cmd_valid_q <= local_hit;
            if (local_hit) cmd_frame_q <= i_rx_frame;

            // A frame arriving in the same cycle the pending one is captured still fits.
            if (fwd_hit) begin
                if (fwd_vld_q && !take_fwd) begin
                    if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                end else begin
                    fwd_vld_q <= 1'b1;
                    fwd_q     <= i_rx_frame;
                end
            end else if (take_fwd) begin
                fwd_vld_q <= 1'b0;
            end

            if (is_master) begin
                stat_tmr_q  <= '0;
                stat_pend_q <= 1'b0;
            end else begin
                stat_tmr_q <= stat_wrap ? '0 : stat_tmr_q + ST_W'(1);
                if (stat_wrap) stat_pend_q <= 1'b1;
                else if (take_stat) stat_pend_q <= 1'b0;
            end

            for (int k = 0; k < N_SLAVE; k++) begin
                if (stat_hit && rx_id == ID_W'(k + 1)) begin
                    alive_tmr_q[k]  <= AL_W'(ALIVE_TIMEOUT);
                    alive_seen_q[k] <= 1'b1;
                end else if (alive_tmr_q[k] != '0) begin
                    alive_tmr_q[k] <= alive_tmr_q[k] - AL_W'(1);
                end
            end
        end
    end

    always_comb begin
        o_slave_alive = '0;
        for (int k = 0; k < N_SLAVE; k++) o_slave_alive[k] = alive_seen_q[k] && alive_tmr_q[k] != '0;
    end

    assign o_zynq_ack     = zynq_ack_q;
    assign o_dsp_ack      = dsp_ack_q;
    assign o_tx_start     = tx_start_q;
    assign o_tx_frame     = tx_frame_q;
    assign o_cmd_valid    = cmd_valid_q;
    assign o_cmd_frame    = cmd_frame_q;
    assign o_stat_valid   = stat_valid_q;
    assign o_stat_id      = stat_id_q;
    assign o_stat_payload = stat_pay_q;
    assign o_timeout_cnt  = timeout_cnt_q;
    assign o_drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_sfp_ring_node.sv
// Bench for sfp_ring_node: scenario tasks with a serializer model and a queue-based expectation of ring traffic.
`timescale 1ns/1ps
module tb_sfp_ring_node;
    localparam int          N_SLAVE = 3, ID_W = 16, FRAME_W = 128, PAY_W = 96;
    localparam int          STAT_PERIOD = 200, TX_TIMEOUT = 20, ALIVE_TIMEOUT = 10000;
    localparam logic [15:0] STAT_CMD = 16'h1111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, zynq_req, dsp_req, tx_done, rx_valid;
    logic [ID_W-1:0]    node_id;
    logic [FRAME_W-1:0] zynq_frame, dsp_frame, rx_frame;
    logic [PAY_W-1:0]   stat_payload;
    logic               o_zynq_ack, o_dsp_ack, o_tx_start, o_cmd_valid, o_stat_valid;
    logic [FRAME_W-1:0] o_tx_frame, o_cmd_frame;
    logic [ID_W-1:0]    o_stat_id;
    logic [PAY_W-1:0]   o_stat_payload;
    logic [N_SLAVE-1:0] o_slave_alive;
    logic [15:0]        o_timeout_cnt, o_drop_cnt;

    int checks = 0, errors = 0;
    logic [FRAME_W-1:0] tx_log [$];
    bit auto_done = 1'b1;

    sfp_ring_node #(.N_SLAVE(N_SLAVE), .ID_W(ID_W), .FRAME_W(FRAME_W), .STAT_CMD(STAT_CMD),
                    .STAT_PERIOD(STAT_PERIOD), .TX_TIMEOUT(TX_TIMEOUT), .ALIVE_TIMEOUT(ALIVE_TIMEOUT)) dut (
        .S_AXI_ACLK(clk), .i_rst(rst), .i_node_id(node_id),
        .i_zynq_req(zynq_req), .i_zynq_frame(zynq_frame), .o_zynq_ack(o_zynq_ack),
        .i_dsp_req(dsp_req), .i_dsp_frame(dsp_frame), .o_dsp_ack(o_dsp_ack),
        .i_stat_payload(stat_payload), .o_tx_start(o_tx_start), .o_tx_frame(o_tx_frame),
        .i_tx_done(tx_done), .i_rx_valid(rx_valid), .i_rx_frame(rx_frame),
        .o_cmd_valid(o_cmd_valid), .o_cmd_frame(o_cmd_frame),
        .o_stat_valid(o_stat_valid), .o_stat_id(o_stat_id), .o_stat_payload(o_stat_payload),
        .o_slave_alive(o_slave_alive), .o_timeout_cnt(o_timeout_cnt), .o_drop_cnt(o_drop_cnt));

    // Serializer: logs each started frame, answers done 3 cycles later when auto_done is set.
    initial begin : serializer
        int done_cd;
        done_cd = 0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0) tx_done = 1'b1;
            end
            if (o_tx_start === 1'b1) begin
                tx_log.push_back(o_tx_frame);
                if (auto_done) done_cd = 3;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [FRAME_W-1:0] mk(input logic [15:0] cmd, input logic [ID_W-1:0] id,
                                              input logic [PAY_W-1:0] pay);
        return {cmd, id, pay};
    endfunction

    function automatic logic [PAY_W-1:0] rpay();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic bit is_own_stat(input logic [FRAME_W-1:0] f, input logic [ID_W-1:0] id);
        return f[FRAME_W-1 -: 16] == STAT_CMD && f[FRAME_W-17 -: ID_W] == id;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [ID_W-1:0] id);
        rst = 1'b1; node_id = id; zynq_req = 1'b0; dsp_req = 1'b0; rx_valid = 1'b0;
        step(3);
        rst = 1'b0;
        tx_log.delete();
    endtask

    task automatic send_rx(input logic [FRAME_W-1:0] f);
        rx_valid = 1'b1; rx_frame = f;
        step(1);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset('0);
        checks++;
        if ({o_zynq_ack, o_dsp_ack, o_tx_start, o_cmd_valid, o_stat_valid} !== 5'b0 || o_tx_frame !== '0)
            begin errors++; $display("FAIL reset_pulses: got %b/%h expected 0", {o_zynq_ack, o_dsp_ack, o_tx_start, o_cmd_valid, o_stat_valid}, o_tx_frame); end
        checks++;
        if (o_slave_alive !== '0 || o_timeout_cnt !== 16'd0 || o_drop_cnt !== 16'd0)
            begin errors++; $display("FAIL reset_counters: got alive=%b to=%0d drop=%0d expected 0", o_slave_alive, o_timeout_cnt, o_drop_cnt); end
        step(10);
        checks++;
        if (tx_log.size() != 0) begin errors++; $display("FAIL idle_master_tx: got %0d frames expected 0", tx_log.size()); end
    endtask

    task automatic test_priority();
        logic [FRAME_W-1:0] zf, df;
        bit got;
        do_reset('0);
        zf = mk(16'h0A0A, 16'd3, rpay());
        df = mk(16'h0B0B, 16'd1, rpay());
        zynq_frame = zf; dsp_frame = df; zynq_req = 1'b1; dsp_req = 1'b1;
        step(1);
        checks++;
        if (o_zynq_ack !== 1'b1 || o_dsp_ack !== 1'b0 || o_tx_frame !== zf)
            begin errors++; $display("FAIL prio_ack: got zack=%b dack=%b frame=%h expected 1 0 %h", o_zynq_ack, o_dsp_ack, o_tx_frame, zf); end
        zynq_req = 1'b0;
        step(1);
        checks++;
        if (o_tx_start !== 1'b1) begin errors++; $display("FAIL prio_start: got %b expected 1", o_tx_start); end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1);
            if (o_dsp_ack === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || o_tx_frame !== df) begin errors++; $display("FAIL prio_dsp: got ack=%b frame=%h expected 1 %h", got, o_tx_frame, df); end
        dsp_req = 1'b0;
        step(10);
        checks++;
        if (tx_log.size() != 2 || tx_log[0] !== zf || tx_log[1] !== df)
            begin errors++; $display("FAIL prio_order: got %0d frames expected 2 (zynq then dsp)", tx_log.size()); end
    endtask

    task automatic test_timeout();
        logic [FRAME_W-1:0] df;
        do_reset('0);
        auto_done = 1'b0;
        df = mk(16'h0C0C, 16'd2, rpay());
        zynq_frame = mk(16'h0D0D, 16'd1, rpay()); dsp_frame = df;
        zynq_req = 1'b1; dsp_req = 1'b1;
        step(1);
        zynq_req = 1'b0;
        step(1 + TX_TIMEOUT);
        checks++;
        if (o_timeout_cnt !== 16'd0 || o_dsp_ack !== 1'b0)
            begin errors++; $display("FAIL timeout_early: got cnt=%0d dack=%b expected 0 0", o_timeout_cnt, o_dsp_ack); end
        step(1);
        checks++;
        if (o_timeout_cnt !== 16'd1) begin errors++; $display("FAIL timeout_cnt: got %0d expected 1", o_timeout_cnt); end
        auto_done = 1'b1;
        step(1);
        checks++;
        if (o_dsp_ack !== 1'b1 || o_tx_frame !== df)
            begin errors++; $display("FAIL timeout_dsp: got ack=%b frame=%h expected 1 %h", o_dsp_ack, o_tx_frame, df); end
        dsp_req = 1'b0;
        step(10);
        checks++;
        if (tx_log.size() != 2 || tx_log[1] !== df || o_timeout_cnt !== 16'd1)
            begin errors++; $display("FAIL timeout_after: got frames=%0d cnt=%0d expected 2 1", tx_log.size(), o_timeout_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        int starts;
        auto_done = 1'b0;
        zynq_frame = mk(16'h0E0E, 16'd3, rpay()); zynq_req = 1'b1;
        step(1);
        zynq_req = 1'b0;
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if (o_tx_start !== 1'b0 || o_timeout_cnt !== 16'd0)
            begin errors++; $display("FAIL midwait_reset: got start=%b cnt=%0d expected 0 0", o_tx_start, o_timeout_cnt); end
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (o_tx_start === 1'b1) starts++;
        end
        checks++;
        if (starts != 0 || o_timeout_cnt !== 16'd0)
            begin errors++; $display("FAIL midwait_idle: got starts=%0d cnt=%0d expected 0 0", starts, o_timeout_cnt); end
        auto_done = 1'b1;
    endtask

    task automatic test_master_status();
        logic [PAY_W-1:0]   pay;
        logic [15:0]        cmd;
        logic [ID_W-1:0]    id;
        logic [N_SLAVE-1:0] exp_alive;
        int                 sel;
        bit                 exp_v;
        do_reset('0);
        pay = rpay();
        send_rx(mk(STAT_CMD, 16'd2, pay));
        checks++;
        if (o_stat_valid !== 1'b1 || o_stat_id !== 16'd2 || o_stat_payload !== pay || o_slave_alive !== 3'b010)
            begin errors++; $display("FAIL stat_dir: got v=%b id=%0d alive=%b expected 1 2 010", o_stat_valid, o_stat_id, o_slave_alive); end
        exp_alive = 3'b010;
        for (int i = 0; i < 40; i++) begin
            cmd = ($urandom_range(0, 2) != 0) ? STAT_CMD : 16'($urandom);
            sel = int'($urandom_range(0, 6));
            id  = (sel <= 4) ? ID_W'(sel) : (sel == 5) ? 16'hFFFF : 16'($urandom);
            pay = rpay();
            exp_v = cmd == STAT_CMD && id >= 1 && id <= N_SLAVE;
            if (exp_v) exp_alive[id - 1] = 1'b1;
            send_rx(mk(cmd, id, pay));
            checks++;
            if (o_stat_valid !== exp_v || o_cmd_valid !== 1'b0 || (exp_v && (o_stat_id !== id || o_stat_payload !== pay)))
                begin errors++; $display("FAIL stat_rand: cmd=%h id=%h got v=%b sid=%h expected %b", cmd, id, o_stat_valid, o_stat_id, exp_v); end
            checks++;
            if (o_slave_alive !== exp_alive)
                begin errors++; $display("FAIL alive_rand: got %b expected %b", o_slave_alive, exp_alive); end
            step(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_alive_timeout();
        do_reset('0);
        send_rx(mk(STAT_CMD, 16'd2, rpay()));
        step(ALIVE_TIMEOUT - 1);
        checks++;
        if (o_slave_alive !== 3'b010) begin errors++; $display("FAIL alive_hold: got %b expected 010", o_slave_alive); end
        step(1);
        checks++;
        if (o_slave_alive !== 3'b000) begin errors++; $display("FAIL alive_expire: got %b expected 000", o_slave_alive); end
    endtask

    task automatic test_slave_rx();
        logic [FRAME_W-1:0] f;
        logic [FRAME_W-1:0] exp_fwd [$];
        logic [FRAME_W-1:0] got_fwd [$];
        logic [ID_W-1:0]    id;
        int                 sel, bad_stat;
        bit                 exp_d;
        stat_payload = rpay();
        do_reset(16'd1);
        for (int i = 0; i < 23; i++) begin
            sel = int'($urandom_range(0, 4));
            if (i < 3) id = (i == 0) ? 16'd1 : (i == 1) ? 16'd3 : 16'hFFFF;
            else       id = (sel <= 3) ? ID_W'(sel) : (sel == 4) ? 16'hFFFF : 16'd0;
            if (i >= 3 && sel == 0) id = 16'($urandom_range(4, 16'hFFFE));
            f = mk(16'($urandom), id, rpay());
            exp_d = id == 16'd1 || id == 16'hFFFF;
            if (id != 16'd1) exp_fwd.push_back(f);
            send_rx(f);
            checks++;
            if (o_cmd_valid !== exp_d || (exp_d && o_cmd_frame !== f) || o_stat_valid !== 1'b0)
                begin errors++; $display("FAIL slave_deliver: id=%h got v=%b expected %b", id, o_cmd_valid, exp_d); end
            step(30);
        end
        bad_stat = 0;
        foreach (tx_log[k]) begin
            if (is_own_stat(tx_log[k], 16'd1)) begin
                if (tx_log[k][PAY_W-1:0] !== stat_payload) bad_stat++;
            end else begin
                got_fwd.push_back(tx_log[k]);
            end
        end
        checks++;
        if (got_fwd.size() != exp_fwd.size() || got_fwd != exp_fwd)
            begin errors++; $display("FAIL slave_forward: got %0d frames expected %0d (or content differs)", got_fwd.size(), exp_fwd.size()); end
        checks++;
        if (bad_stat != 0) begin errors++; $display("FAIL slave_stat_payload: got %0d bad frames expected 0", bad_stat); end
    endtask

    task automatic test_drop();
        logic [FRAME_W-1:0] a, b, c;
        logic [FRAME_W-1:0] got_fwd [$];
        bit got;
        do_reset(16'd1);
        auto_done = 1'b0;
        a = mk(16'h2222, 16'd3, rpay());
        b = mk(16'h3333, 16'd2, rpay());
        c = mk(16'h4444, 16'd3, rpay());
        send_rx(a);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (o_tx_start === 1'b1 && o_tx_frame === a) got = 1'b1;
            else step(1);
        end
        checks++;
        if (!got) begin errors++; $display("FAIL drop_first_start: got none expected tx_start of first frame"); end
        step(2);
        send_rx(b);
        send_rx(c);
        checks++;
        if (o_drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt: got %0d expected 1", o_drop_cnt); end
        auto_done = 1'b1;
        step(60);
        foreach (tx_log[k]) if (!is_own_stat(tx_log[k], 16'd1)) got_fwd.push_back(tx_log[k]);
        checks++;
        if (got_fwd.size() != 2 || got_fwd[0] !== a || got_fwd[1] !== b || o_drop_cnt !== 16'd1)
            begin errors++; $display("FAIL drop_sent: got %0d frames drop=%0d expected 2 frames drop=1", got_fwd.size(), o_drop_cnt); end
    endtask

    task automatic test_status_period();
        int n_ok, n_bad;
        stat_payload = rpay();
        do_reset(16'd2);
        step(5 * STAT_PERIOD + 10);
        n_ok = 0; n_bad = 0;
        foreach (tx_log[k]) begin
            if (is_own_stat(tx_log[k], 16'd2) && tx_log[k][PAY_W-1:0] === stat_payload) n_ok++;
            else n_bad++;
        end
        checks++;
        if (n_ok != 5 || n_bad != 0)
            begin errors++; $display("FAIL stat_period: got %0d good %0d other expected 5 0", n_ok, n_bad); end
    endtask

    initial begin
        rst = 1'b1; node_id = '0; zynq_req = 1'b0; dsp_req = 1'b0; rx_valid = 1'b0;
        zynq_frame = '0; dsp_frame = '0; rx_frame = '0; stat_payload = '0;
        test_reset();
        test_priority();
        test_timeout();
        test_reset_mid_wait();
        test_master_status();
        test_alive_timeout();
        test_slave_rx();
        test_drop();
        test_status_period();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
